// File: rtl/rgb_modulate_pipe.sv
// -----------------------------------------------------------------------------
// rgb_modulate_pipe
//
// Multi-channel colour modulator for the shading path. Each beat combines a
// per-channel colour operand `a` with a modulating operand `b` (texture sample
// or light intensity) under a per-beat mode. The path is a STAGES-deep pipeline
// with valid/ready handshakes on both sides. Empty stages fill even while the
// output is stalled.
//
// Parameters
//   CH      number of colour channels processed in parallel (1..4)
//   W       component width in bits (4..16)
//   STAGES  pipeline depth in register stages (1..4). This is the no-stall latency.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input beat present
//   in_ready   block accepts the beat this cycle (combinational from out_ready)
//   in_mode    0 MUL_TRUNC, 1 MUL_NORM, 2 ADD_SAT, 3 PASS_A
//   in_a       operand A, channel k at bits [k*W +: W]
//   in_b       operand B, same packing
//   out_valid  result beat present
//   out_ready  downstream accepts the result
//   out_data   result, same packing
//   out_sat    per-channel flag: ADD_SAT clipped this channel
//
// Optional feature (macro RGB_MOD_STATS_EN)
//   When defined, two more outputs are present. Both reset to 0 and wrap modulo 2^32.
//   stat_beats  count of output transfers
//   stat_sat    count of output transfers with any out_sat bit set
// -----------------------------------------------------------------------------
module rgb_modulate_pipe #(
    parameter int CH     = 3,
    parameter int W      = 8,
    parameter int STAGES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_mode,
    input  logic [CH*W-1:0] in_a,
    input  logic [CH*W-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CH*W-1:0] out_data,
    output logic [CH-1:0]   out_sat
`ifdef RGB_MOD_STATS_EN
    ,
    output logic [31:0]     stat_beats,
    output logic [31:0]     stat_sat
`endif
);

    localparam int LAST = STAGES - 1;
    // Rounding constant for MUL_NORM: 2^(W-1).
    localparam logic [2*W-1:0] HALF = (2*W)'(1) << (W - 1);

    typedef enum logic [1:0] {
        MODE_MUL_TRUNC = 2'd0,
        MODE_MUL_NORM  = 2'd1,
        MODE_ADD_SAT   = 2'd2,
        MODE_PASS_A    = 2'd3
    } mode_e;

    // Stage payload after the multiply. The full product, the full sum and the
    // raw A operand are carried so that any mode can resolve later.
    typedef struct packed {
        mode_e                   mode;
        logic [CH-1:0][2*W-1:0]  prod;
        logic [CH-1:0][W:0]      sum;
        logic [CH-1:0][W-1:0]    a;
    } raw_t;

    // Final per-beat result as presented on the output.
    typedef struct packed {
        logic [CH-1:0][W-1:0] data;
        logic [CH-1:0]        sat;
    } res_t;

    function automatic raw_t make_raw(input logic [1:0]      mode,
                                      input logic [CH*W-1:0] a,
                                      input logic [CH*W-1:0] b);
        raw_t r;
        r.mode = mode_e'(mode);
        for (int k = 0; k < CH; k++) begin
            r.prod[k] = (2*W)'(a[k*W +: W]) * (2*W)'(b[k*W +: W]);
            r.sum[k]  = (W+1)'(a[k*W +: W]) + (W+1)'(b[k*W +: W]);
            r.a[k]    = a[k*W +: W];
        end
        return r;
    endfunction

    function automatic res_t finish(input raw_t r);
        res_t             o;
        logic [2*W-1:0]   norm;
        o = '0;
        for (int k = 0; k < CH; k++) begin
            // The sum cannot exceed 2^(2W) - 2^(W-1) - 1, so 2W bits are enough.
            norm = r.prod[k] + (r.prod[k] >> W) + HALF;
            case (r.mode)
                MODE_MUL_TRUNC: o.data[k] = r.prod[k][2*W-1:W];
                MODE_MUL_NORM:  o.data[k] = W'(norm >> W);
                MODE_ADD_SAT: begin
                    if (r.sum[k][W]) begin
                        o.data[k] = '1;
                        o.sat[k]  = 1'b1;
                    end else begin
                        o.data[k] = r.sum[k][W-1:0];
                    end
                end
                default:        o.data[k] = r.a[k];   // MODE_PASS_A
            endcase
        end
        return o;
    endfunction

    // -------------------------------------------------------------------------
    // Handshake / stall chain
    // -------------------------------------------------------------------------
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] en;          // stage i loads this cycle
    logic [STAGES-1:0] feed_valid;  // valid bit arriving at stage i

    // Stage i can load unless it and every stage after it are full and the
    // output is stalled. Writing the rule in this closed form avoids a
    // self-referencing chain through en[].
    always_comb begin
        // NOTE: give every always_comb output a default first. A path that
        // leaves it unassigned would infer a latch.
        en = '0;
        for (int i = 0; i < STAGES; i++) begin
            en[i] = out_ready |
                    ~(&(valid_q | ((STAGES'(1) << i) - STAGES'(1))));
        end
    end

    assign feed_valid = (valid_q << 1) | STAGES'(in_valid);
    assign in_ready   = en[0];
    assign out_valid  = valid_q[LAST];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. Every stage
            // then reads its neighbour's value from before the clock edge.
            for (int i = 0; i < STAGES; i++) begin
                if (en[i]) valid_q[i] <= feed_valid[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    generate
        if (STAGES == 1) begin : g_single
            res_t res_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    // NOTE: the data registers are reset along with the valid
                    // bits so that out_data and out_sat read 0 out of reset.
                    // These are a few pipeline flops, not a memory array.
                    res_q <= '0;
                end else if (en[0] && in_valid) begin
                    res_q <= finish(make_raw(in_mode, in_a, in_b));
                end
            end

            assign out_data = res_q.data;
            assign out_sat  = res_q.sat;
        end else begin : g_multi
            // raw_q[0] holds the product. Any further raw stages are pure delay.
            raw_t raw_q [STAGES-1];
            res_t res_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < STAGES - 1; i++) raw_q[i] <= '0;
                end else begin
                    if (en[0] && feed_valid[0])
                        raw_q[0] <= make_raw(in_mode, in_a, in_b);
                    for (int i = 1; i < STAGES - 1; i++) begin
                        if (en[i] && feed_valid[i]) raw_q[i] <= raw_q[i-1];
                    end
                end
            end

            // Rounding, mode select and saturation resolve entering the last stage.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    res_q <= '0;
                end else if (en[LAST] && feed_valid[LAST]) begin
                    res_q <= finish(raw_q[STAGES-2]);
                end
            end

            assign out_data = res_q.data;
            assign out_sat  = res_q.sat;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Optional output statistics
    // -------------------------------------------------------------------------
`ifdef RGB_MOD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_beats <= '0;
            stat_sat   <= '0;
        end else if (out_valid && out_ready) begin
            stat_beats <= stat_beats + 32'd1;
            if (|out_sat) stat_sat <= stat_sat + 32'd1;
        end
    end
`else
    // This build has no statistics counters.
`endif

endmodule

// File: tb/tb_rgb_modulate_pipe.sv
// -----------------------------------------------------------------------------
// tb_rgb_modulate_pipe
//
// Directed bench for rgb_modulate_pipe. It uses two instances:
//   dut  : default parameters (CH=3, W=8, STAGES=2)
//   dut1 : CH=4, W=12, STAGES=1
// Every expected value is a hand-computed constant in the vectors below.
// Inputs are driven and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_rgb_modulate_pipe;

    logic        clk;
    logic        rst_n;

    // Default instance signals.
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [1:0]  in_mode;
    logic [23:0] in_a, in_b, out_data;
    logic [2:0]  out_sat;

    // Single-stage, 4-channel, 12-bit instance signals.
    logic        s1_in_valid, s1_in_ready, s1_out_valid, s1_out_ready;
    logic [1:0]  s1_in_mode;
    logic [47:0] s1_in_a, s1_in_b, s1_out_data;
    logic [3:0]  s1_out_sat;

`ifdef RGB_MOD_STATS_EN
    logic [31:0] stat_beats, stat_sat, s1_stat_beats, s1_stat_sat;
`endif

    int n_vec = 0;
    int n_err = 0;

    rgb_modulate_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
`ifdef RGB_MOD_STATS_EN
        ,
        .stat_beats(stat_beats),
        .stat_sat  (stat_sat)
`endif
    );

    rgb_modulate_pipe #(.CH(4), .W(12), .STAGES(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_in_valid),
        .in_ready  (s1_in_ready),
        .in_mode   (s1_in_mode),
        .in_a      (s1_in_a),
        .in_b      (s1_in_b),
        .out_valid (s1_out_valid),
        .out_ready (s1_out_ready),
        .out_data  (s1_out_data),
        .out_sat   (s1_out_sat)
`ifdef RGB_MOD_STATS_EN
        ,
        .stat_beats(s1_stat_beats),
        .stat_sat  (s1_stat_sat)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One beat through the default instance with out_ready held high.
    // The task measures the latency and checks the result.
    task automatic single(input string tag, input logic [1:0] mode,
                          input logic [23:0] a, input logic [23:0] b,
                          input logic [23:0] exp_d, input logic [2:0] exp_s);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; in_mode = mode; in_a = a; in_b = b;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'd2);
        check({tag, "_data"}, 64'(out_data), 64'(exp_d));
        check({tag, "_sat"}, 64'(out_sat), 64'(exp_s));
    endtask

    // One beat through the single-stage instance. Latency is one cycle.
    task automatic single1(input string tag, input logic [1:0] mode,
                           input logic [47:0] a, input logic [47:0] b,
                           input logic [47:0] exp_d, input logic [3:0] exp_s);
        @(negedge clk);
        s1_in_valid = 1'b1; s1_in_mode = mode; s1_in_a = a; s1_in_b = b;
        #1;
        check({tag, "_in_ready"}, 64'(s1_in_ready), 64'd1);
        check({tag, "_pre_valid"}, 64'(s1_out_valid), 64'd0);
        @(negedge clk);
        s1_in_valid = 1'b0;
        check({tag, "_valid"}, 64'(s1_out_valid), 64'd1);
        check({tag, "_data"}, 64'(s1_out_data), 64'(exp_d));
        check({tag, "_sat"}, 64'(s1_out_sat), 64'(exp_s));
    endtask

    // Stream vectors: mode, a, b, expected data, expected sat.
    logic [1:0]  sm [8];
    logic [23:0] sa [8];
    logic [23:0] sb [8];
    logic [23:0] sd [8];
    logic [2:0]  ss [8];

    initial begin
        int          sent;
        int          rcv;
        logic        held_v;
        logic [23:0] held_d;
        logic [2:0]  held_s;
        logic        exp_rdy;

        sm = '{2'd0,      2'd1,      2'd2,      2'd3,      2'd0,      2'd2,      2'd1,      2'd0};
        sa = '{24'hFFFFFF, 24'h8080FF, 24'hFF64C8, 24'h123456, 24'h808080, 24'h00FEFF, 24'hFFFFFF, 24'hFF8040};
        sb = '{24'hFFFFFF, 24'h80FFFF, 24'h003264, 24'hFFFFFF, 24'h808080, 24'h000101, 24'h102030, 24'h804020};
        sd = '{24'hFEFEFE, 24'h4080FF, 24'hFF96FF, 24'h123456, 24'h404040, 24'h00FFFF, 24'h102030, 24'h7F2008};
        ss = '{3'b000,    3'b000,    3'b001,    3'b000,    3'b000,    3'b001,    3'b000,    3'b000};

        rst_n = 1'b0;
        in_valid = 1'b0; in_mode = 2'd0; in_a = '0; in_b = '0; out_ready = 1'b1;
        s1_in_valid = 1'b0; s1_in_mode = 2'd0; s1_in_a = '0; s1_in_b = '0; s1_out_ready = 1'b1;

        // Reset state.
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_sat", 64'(out_sat), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Single beats: two-cycle latency and per-mode arithmetic.
        single("trunc_ff",   2'd0, 24'hFFFFFF, 24'hFFFFFF, 24'hFEFEFE, 3'b000);
        single("norm_ff",    2'd1, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 3'b000);
        single("norm_mix",   2'd1, 24'h8080FF, 24'h80FFFF, 24'h4080FF, 3'b000);
        single("trunc_80",   2'd0, 24'h808080, 24'h808080, 24'h404040, 3'b000);
        single("addsat",     2'd2, 24'hFF64C8, 24'h003264, 24'hFF96FF, 3'b001);
        single("addsat_edge",2'd2, 24'h00FEFF, 24'h000101, 24'h00FFFF, 3'b001);
        single("pass_a",     2'd3, 24'h123456, 24'hABCDEF, 24'h123456, 3'b000);

        // Stream of 8 mixed-mode beats. out_ready is low for 5 cycles mid-stream.
        sent = 0; rcv = 0; held_v = 1'b0; held_d = '0; held_s = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc < 8);
            if (sent < 8) begin
                in_valid = 1'b1; in_mode = sm[sent]; in_a = sa[sent]; in_b = sb[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            exp_rdy = out_ready || ((sent - rcv) < 2);
            if (in_valid) check("stream_in_ready", 64'(in_ready), 64'(exp_rdy));
            if (out_valid && !out_ready) begin
                if (held_v) begin
                    check("stall_hold_data", 64'(out_data), 64'(held_d));
                    check("stall_hold_sat", 64'(out_sat), 64'(held_s));
                end
                held_v = 1'b1; held_d = out_data; held_s = out_sat;
            end else begin
                held_v = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (rcv < 8) begin
                    check($sformatf("stream_d%0d", rcv), 64'(out_data), 64'(sd[rcv]));
                    check($sformatf("stream_s%0d", rcv), 64'(out_sat), 64'(ss[rcv]));
                end else begin
                    check("stream_dup", 64'(out_valid), 64'd0);
                end
                rcv++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", 64'(sent), 64'd8);
        check("stream_recv", 64'(rcv), 64'd8);

        // Reset with two beats in flight.
        @(negedge clk);
        in_valid = 1'b1; in_mode = 2'd3; in_a = 24'hAAAAAA; in_b = '0;
        @(negedge clk);
        in_a = 24'h555555;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("rstmid_pre_valid", 64'(out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", 64'(out_valid), 64'd0);
        check("rstmid_out_data", 64'(out_data), 64'd0);
        check("rstmid_out_sat", 64'(out_sat), 64'd0);
`ifdef RGB_MOD_STATS_EN
        check("rstmid_stat_beats", 64'(stat_beats), 64'd0);
        check("rstmid_stat_sat", 64'(stat_sat), 64'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("rstmid_no_stale", 64'(out_valid), 64'd0);
        end

        // Single-stage, 4-channel, 12-bit instance.
        single1("s1_norm", 2'd1, 48'hFFF_FFF_FFF_FFF, 48'h7A3_7A3_7A3_7A3,
                48'h7A3_7A3_7A3_7A3, 4'b0000);
        @(negedge clk);
        #1;
`ifdef RGB_MOD_STATS_EN
        check("s1_stat_beats", 64'(s1_stat_beats), 64'd1);
`endif
        check("s1_drained", 64'(s1_out_valid), 64'd0);
        single1("s1_addsat", 2'd2, 48'h000_800_FFF_7FF, 48'h000_800_001_001,
                48'h000_FFF_FFF_800, 4'b0110);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rgb_modulate_pipe.md
Name: rgb_modulate_pipe

Overview:
Multi-channel colour modulator for the shading path. Combines a per-channel colour operand `a` with a modulating operand `b` (texture sample, light intensity) under a per-beat mode. It generalises the fixed 8-bit, single-channel, single-register multiply to CH channels, W-bit components and a STAGES-deep pipeline with valid/ready backpressure. It sits between the texture/lighting units and the framebuffer write stage.

Parameters:
- CH, 3, number of colour channels processed in parallel (1..4).
- W, 8, component width in bits (4..16).
- STAGES, 2, pipeline depth in register stages (1..4); fixes the no-stall latency.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_mode  input  2  operation for this beat: 0 MUL_TRUNC, 1 MUL_NORM, 2 ADD_SAT, 3 PASS_A.
- in_a  input  CH*W  operand A; channel k at bits [k*W +: W].
- in_b  input  CH*W  operand B, same packing.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result.
- out_data  output  CH*W  result, same packing.
- out_sat  output  CH  per-channel flag: ADD_SAT clipped this channel.

Behaviour:
- Reset (async, rst_n=0): all stage valid bits 0. out_valid=0, out_data=0, out_sat=0. in_ready=1 from the first cycle after deassertion.
- A transfer occurs on a cycle with valid&ready high, on either side.
- Pipeline: stage registers S0..S(STAGES-1), each holding a valid bit, mode, operands or partial results.
  - Stage i loads when it is empty or stage i+1 loads in the same cycle.
  - The last stage advances when out_valid=0 or out_ready=1.
  - in_ready = S0 empty OR S0 advancing. in_ready is combinational from out_ready through the stall chain. No combinational path from in_* to out_*.
  - Bubbles collapse: an empty stage fills even while downstream is stalled.
- Latency: exactly STAGES cycles from input transfer to out_valid when out_ready=1 throughout. Throughput 1 beat/cycle.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_sat hold stable. Up to STAGES beats are buffered; no beat is dropped or duplicated; order is preserved.
- Arithmetic per channel, p = a*b as a 2W-bit unsigned product:
  - MUL_TRUNC: result = p[2W-1:W].
  - MUL_NORM: result = (p + (p>>W) + 2^(W-1)) >> W, truncated to W bits. This approximates round(a*b/(2^W-1)); a=max gives b exactly.
  - ADD_SAT: s = a+b (W+1 bits). If s[W]=1, result = 2^W-1 and sat=1; otherwise result = s[W-1:0] and sat=0.
  - PASS_A: result = a.
  - sat=0 for every mode except ADD_SAT.
- Stage placement: the multiply completes in S0. Rounding, mode select and saturation resolve by the last stage. With STAGES=1 everything is in S0. Extra stages are pure delay.
- Mode is captured with its beat; consecutive beats may use different modes with no bubble.
- Reset mid-stream: in-flight beats are discarded, outputs return to reset values immediately (asynchronous).
- Simultaneous input transfer and output transfer with the pipeline full: both occur and occupancy is unchanged.

Optional Feature:
RGB_MOD_STATS_EN
- Defined: adds output ports `stat_beats` (32) and `stat_sat` (32).
  - `stat_beats` counts output transfers.
  - `stat_sat` counts output transfers with any out_sat bit set.
  - Both counters wrap modulo 2^32 and reset to 0 on rst_n.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Defaults, mode 0, a=b=0xFF in every channel, out_ready=1 -> after exactly 2 cycles out_data channels = 0xFE, out_sat=0.
- Mode 1 cases -> a=b=0xFF gives 0xFF; a=0x80,b=0xFF gives 0x80; a=b=0x80 gives 0x40. Mode 0 with a=b=0x80 also gives 0x40.
- Mode 2, ch0 200+100, ch1 100+50, ch2 255+0 -> outputs 255/150/255, out_sat=3'b001.
- Stream 8 beats with mixed modes; hold out_ready=0 for 5 cycles mid-stream -> in_ready drops after 2 buffered beats, output holds stable, all 8 results arrive in order with none lost.
- Assert rst_n=0 while 2 beats are in flight -> out_valid=0 immediately, no stale beat appears after release. With RGB_MOD_STATS_EN defined, counters read 0.
- STAGES=1, CH=4, W=12, mode 1, a=0xFFF, b=0x7A3 -> out_data=0x7A3 after 1 cycle. With RGB_MOD_STATS_EN defined, stat_beats increments once.
